// File: rtl/nes_pad_reader.sv
// Multi-pad NES controller reader: shared latch/pad_clk, parallel serial capture,
// per-frame button vectors with press/release pulses and a frame-valid strobe.
module nes_pad_reader #(
    parameter int NUM_PADS    = 2,
    parameter int HALF_PERIOD = 256,
    parameter int FRAME_TICKS = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    poll_en,
    input  logic [NUM_PADS-1:0]     data,
    output logic                    latch,
    output logic                    pad_clk,
    output logic [8*NUM_PADS-1:0]   buttons,
    output logic [8*NUM_PADS-1:0]   pressed,
    output logic [8*NUM_PADS-1:0]   released,
    output logic                    frame_valid
);

    localparam int HW = $clog2(HALF_PERIOD);
    localparam int SW = $clog2(FRAME_TICKS);
    localparam int BW = 8 * NUM_PADS;

    localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_PERIOD - 1);
    localparam logic [SW-1:0] SLOT_SHIFT = SW'(8);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(FRAME_TICKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SHIFT,
        ST_COMMIT,
        ST_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   half_q, half_d;
    logic            phase_q, phase_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [BW-1:0]   shift_q, shift_d;
    logic [BW-1:0]   buttons_q, buttons_d;
    logic [BW-1:0]   pressed_q, pressed_d;
    logic [BW-1:0]   released_q, released_d;
    logic            frame_valid_q, frame_valid_d;
    logic            latch_q, latch_d;
    logic            pad_clk_q, pad_clk_d;
    logic            slot_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            half_q        <= '0;
            phase_q       <= 1'b0;
            slot_q        <= '0;
            shift_q       <= '0;
            buttons_q     <= '0;
            pressed_q     <= '0;
            released_q    <= '0;
            frame_valid_q <= 1'b0;
            latch_q       <= 1'b0;
            pad_clk_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            half_q        <= half_d;
            phase_q       <= phase_d;
            slot_q        <= slot_d;
            shift_q       <= shift_d;
            buttons_q     <= buttons_d;
            pressed_q     <= pressed_d;
            released_q    <= released_d;
            frame_valid_q <= frame_valid_d;
            latch_q       <= latch_d;
            pad_clk_q     <= pad_clk_d;
        end
    end

    // Position counters (half-slot cycle, slot half, slot index) advance every cycle
    // outside IDLE; the slot index is cleared explicitly when a frame wraps.
    always_comb begin
        state_d       = state_q;
        half_d        = half_q;
        phase_d       = phase_q;
        slot_d        = slot_q;
        shift_d       = shift_q;
        buttons_d     = buttons_q;
        pressed_d     = '0;
        released_d    = '0;
        frame_valid_d = 1'b0;
        slot_end      = (half_q == HALF_LAST) && phase_q;

        if (state_q != ST_IDLE) begin
            if (half_q == HALF_LAST) begin
                half_d  = '0;
                phase_d = ~phase_q;
                if (phase_q) begin
                    slot_d = slot_q + SW'(1);
                end
            end else begin
                half_d = half_q + HW'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (poll_en) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (slot_end) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Sample on the last low cycle of each slot, just before pad_clk rises.
                if (!phase_q && (half_q == HALF_LAST)) begin
                    for (int p = 0; p < NUM_PADS; p++) begin
                        for (int k = 0; k < 8; k++) begin
                            if (slot_q == SW'(k + 1)) begin
                                shift_d[8*p + k] = ~data[p];
                            end
                        end
                    end
                end
                if (slot_end && (slot_q == SLOT_SHIFT)) begin
                    state_d       = ST_COMMIT;
                    buttons_d     = shift_q;
                    pressed_d     = shift_q & ~buttons_q;
                    released_d    = ~shift_q & buttons_q;
                    frame_valid_d = 1'b1;
                end
            end
            ST_COMMIT: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (slot_end && (slot_q == SLOT_LAST)) begin
                    slot_d  = '0;
                    state_d = poll_en ? ST_LATCH : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                half_d  = '0;
                phase_d = 1'b0;
                slot_d  = '0;
            end
        endcase

        latch_d   = (state_d == ST_LATCH);
        pad_clk_d = (state_d == ST_SHIFT) && phase_d;
    end

    assign latch       = latch_q;
    assign pad_clk     = pad_clk_q;
    assign buttons     = buttons_q;
    assign pressed     = pressed_q;
    assign released    = released_q;
    assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Randomised bench for nes_pad_reader: a frame-position model predicts every output
// each cycle, plus directed frame scenarios with constant expectations.
module tb_nes_pad_reader;

    localparam int NP = 2;
    localparam int HP = 4;
    localparam int FT = 16;
    localparam int S  = 2 * HP;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            poll_en;
    logic [NP-1:0]   data;
    logic            latch;
    logic            pad_clk;
    logic [8*NP-1:0] buttons;
    logic [8*NP-1:0] pressed;
    logic [8*NP-1:0] released;
    logic            frame_valid;

    int total = 0;
    int bad   = 0;

    bit              mActive;
    int              mPos;
    logic [8*NP-1:0] mNew;
    logic [8*NP-1:0] expButtons, expPressed, expReleased;
    logic            expLatch, expPadClk, expFv;
    logic [7:0]      curPat [NP];

    nes_pad_reader #(
        .NUM_PADS   (NP),
        .HALF_PERIOD(HP),
        .FRAME_TICKS(FT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .poll_en    (poll_en),
        .data       (data),
        .latch      (latch),
        .pad_clk    (pad_clk),
        .buttons    (buttons),
        .pressed    (pressed),
        .released   (released),
        .frame_valid(frame_valid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mActive     = 1'b0;
        mPos        = 0;
        mNew        = '0;
        expButtons  = '0;
        expPressed  = '0;
        expReleased = '0;
        expLatch    = 1'b0;
        expPadClk   = 1'b0;
        expFv       = 1'b0;
    endtask

    // Model works on the cycle position within the frame: it first retires the cycle
    // that just ended, then derives the outputs expected for the cycle now starting.
    task automatic modelStep();
        if (!rst_n) begin
            modelReset();
            return;
        end
        if (!mActive) begin
            if (poll_en) begin
                mActive = 1'b1;
                mPos    = 0;
            end
        end else begin
            if (mPos >= S && mPos < 9*S && (mPos % S) == HP - 1) begin
                for (int p = 0; p < NP; p++) begin
                    mNew[8*p + mPos/S - 1] = ~data[p];
                end
            end
            if (mPos == FT*S - 1) begin
                if (poll_en) mPos = 0;
                else         mActive = 1'b0;
            end else begin
                mPos++;
            end
        end
        expPressed  = '0;
        expReleased = '0;
        expFv       = 1'b0;
        if (mActive && mPos == 9*S) begin
            expPressed  = mNew & ~expButtons;
            expReleased = ~mNew & expButtons;
            expButtons  = mNew;
            expFv       = 1'b1;
        end
        expLatch  = mActive && (mPos < S);
        expPadClk = mActive && (mPos >= S) && (mPos < 9*S) && ((mPos % S) >= HP);
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("latch",       32'(latch),       32'(expLatch));
        checkOutput("pad_clk",     32'(pad_clk),     32'(expPadClk));
        checkOutput("buttons",     32'(buttons),     32'(expButtons));
        checkOutput("pressed",     32'(pressed),     32'(expPressed));
        checkOutput("released",    32'(released),    32'(expReleased));
        checkOutput("frame_valid", 32'(frame_valid), 32'(expFv));
        for (int p = 0; p < NP; p++) begin
            if (mActive && mPos >= S && mPos < 9*S && (mPos % S) == HP - 1)
                data[p] = ~curPat[p][mPos/S - 1];
            else
                data[p] = 1'($urandom);
        end
    endtask

    task automatic runToPos(input int target, input int budget, output int steps);
        steps = 0;
        do begin
            applyStimulus();
            steps++;
        end while (!(mActive && mPos == target) && steps < budget);
        checkOutput("reach_pos", (mActive && mPos == target) ? 32'(mPos) : 32'hFFFF_FFFF, 32'(target));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no finish want finish by 1000000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int steps;
        modelReset();
        rst_n     = 1'b0;
        poll_en   = 1'b1;
        data      = '1;
        curPat[0] = 8'h81;
        curPat[1] = 8'h00;

        repeat (3) applyStimulus();
        checkOutput("rst_buttons", 32'(buttons), 32'h0);
        checkOutput("rst_latch",   32'(latch),   32'h0);

        rst_n = 1'b1;
        runToPos(0, 10, steps);
        checkOutput("first_latch_delay", 32'(steps), 32'd1);

        runToPos(9*S, 200, steps);
        checkOutput("f1_commit_cycle", 32'(steps), 32'd72);
        checkOutput("f1_buttons",  32'(buttons),     32'h0081);
        checkOutput("f1_pressed",  32'(pressed),     32'h0081);
        checkOutput("f1_released", 32'(released),    32'h0000);
        checkOutput("f1_fv",       32'(frame_valid), 32'h1);
        applyStimulus();
        checkOutput("f1_pressed_drop", 32'(pressed),     32'h0);
        checkOutput("f1_fv_drop",      32'(frame_valid), 32'h0);
        runToPos(0, 200, steps);
        checkOutput("frame_period", 32'(steps), 32'd55);

        runToPos(9*S, 200, steps);
        checkOutput("f2_buttons", 32'(buttons), 32'h0081);
        checkOutput("f2_pressed", 32'(pressed), 32'h0000);

        curPat[0] = 8'h80;
        runToPos(9*S, 200, steps);
        checkOutput("f3_buttons",  32'(buttons),  32'h0080);
        checkOutput("f3_released", 32'(released), 32'h0001);
        checkOutput("f3_pressed",  32'(pressed),  32'h0000);

        curPat[1] = 8'h18;
        runToPos(9*S, 200, steps);
        checkOutput("f4_pad1", 32'(buttons[15:8]), 32'h18);
        checkOutput("f4_pad0", 32'(buttons[7:0]),  32'h80);
        checkOutput("f4_pressed", 32'(pressed),    32'h1800);

        curPat[0] = 8'h5a;
        curPat[1] = 8'ha5;
        runToPos(40, 200, steps);
        poll_en = 1'b0;
        runToPos(9*S, 200, steps);
        checkOutput("f5_fv",      32'(frame_valid), 32'h1);
        checkOutput("f5_buttons", 32'(buttons),     32'ha55a);
        repeat (55) applyStimulus();
        applyStimulus();
        checkOutput("no_latch_128", 32'(latch),   32'h0);
        checkOutput("held_buttons", 32'(buttons), 32'ha55a);
        repeat (72) applyStimulus();
        poll_en = 1'b1;
        applyStimulus();
        checkOutput("latch_201", 32'(latch), 32'h1);

        curPat[0] = 8'h3c;
        curPat[1] = 8'hc3;
        runToPos(40, 200, steps);
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("arst_latch",    32'(latch),       32'h0);
        checkOutput("arst_pad_clk",  32'(pad_clk),     32'h0);
        checkOutput("arst_buttons",  32'(buttons),     32'h0);
        checkOutput("arst_pressed",  32'(pressed),     32'h0);
        checkOutput("arst_released", 32'(released),    32'h0);
        checkOutput("arst_fv",       32'(frame_valid), 32'h0);
        repeat (2) applyStimulus();
        rst_n = 1'b1;
        runToPos(0, 5, steps);
        checkOutput("rst_relatch", 32'(steps), 32'd1);
        runToPos(9*S, 200, steps);
        checkOutput("rst_commit_cycle", 32'(steps), 32'd72);
        checkOutput("rst_buttons_new",  32'(buttons), 32'hc33c);
        checkOutput("rst_pressed_new",  32'(pressed), 32'hc33c);

        for (int f = 0; f < 8; f++) begin
            curPat[0] = 8'($urandom);
            curPat[1] = 8'($urandom);
            runToPos(0, 300, steps);
            runToPos(20 + $urandom_range(0, 40), 200, steps);
            poll_en = 1'($urandom_range(0, 1));
            runToPos(9*S, 200, steps);
            checkOutput("rand_buttons", 32'(buttons), 32'({curPat[1], curPat[0]}));
            if (!poll_en) begin
                repeat (60 + $urandom_range(0, 30)) applyStimulus();
                poll_en = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
